npu_dot_engine: RTL and testbench

NPU_DOT_ENGINE -- requirements
Module: npu_dot_engine

---
 rtl/npu_dot_engine.sv | 187 ++++++++++++++++++
 tb/tb_npu_dot_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_dot_engine.sv
`default_nettype none
// ============================================================================
// Module      : npu_dot_engine
// Description : Signed dot-product engine. It fetches two vectors from external
//               synchronous RAMs and accumulates their products in full
//               precision. It then adds a bias, shifts, applies an optional
//               ReLU and saturates the result. The result is held under a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_dot_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W:0]          vec_len,
  input  logic [ADDR_W-1:0]        feat_base,
  input  logic [ADDR_W-1:0]        wgt_base,
  input  logic signed [DATA_W-1:0] bias,
  input  logic [3:0]               out_shift,
  input  logic                     relu_en,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        feat_addr,
  output logic [ADDR_W-1:0]        wgt_addr,
  input  logic signed [DATA_W-1:0] feat_rdata,
  input  logic signed [DATA_W-1:0] wgt_rdata,
  output logic signed [OUT_W-1:0]  result_out,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy,
  output logic                     sat_flag
);

  // The accumulator must hold 2^ADDR_W worst-case products plus the bias
  // without wrapping, and must be at least as wide as the result.
  if (ACC_W < 2*DATA_W + ADDR_W + 1 || ACC_W < OUT_W) begin : g_acc_w_check
    $error("npu_dot_engine: ACC_W too small for DATA_W/ADDR_W/OUT_W");
  end

  localparam int PROD_W = 2*DATA_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [ADDR_W:0]          len_q;
  logic [ADDR_W:0]          rd_cnt;
  logic [ADDR_W:0]          rd_cnt_inc;
  logic [ADDR_W:0]          len_clamped;
  logic signed [DATA_W-1:0] bias_q;
  logic [3:0]               shift_q;
  logic                     relu_q;
  logic                     rd_pending;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  rectified;
  logic signed [OUT_W-1:0]  res_sat;
  logic                     res_clip;

  assign len_clamped = (vec_len > MAX_LEN) ? MAX_LEN : vec_len;
  assign rd_cnt_inc  = rd_cnt + CNT_ONE;

  assign prod      = feat_rdata * wgt_rdata;
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext  = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
  assign biased    = acc + bias_ext;
  assign shifted   = biased >>> shift_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the last read cycle is the one whose count reaches len_q
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (len_clamped == '0) ? S_DRAIN : S_FETCH;
      S_FETCH:  if (rd_cnt_inc == len_q) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_HOLD;
      S_HOLD:   if (result_valid && result_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_rd_en = (state == S_FETCH);
    busy      = (state != S_IDLE);
  end

  // ReLU then saturation of the shifted sum
  always_comb begin
    rectified = shifted;
    if (relu_q && shifted[ACC_W-1]) rectified = '0;
    res_sat  = rectified[OUT_W-1:0];
    res_clip = 1'b0;
    if (rectified > SAT_HI) begin
      res_sat  = OUT_MAX;
      res_clip = 1'b1;
    end else if (rectified < SAT_LO) begin
      res_sat  = OUT_MIN;
      res_clip = 1'b1;
    end
  end

  // Job latch, address generation, accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      rd_cnt       <= '0;
      bias_q       <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      rd_pending   <= 1'b0;
      acc          <= '0;
      feat_addr    <= '0;
      wgt_addr     <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      // Read data arrives one cycle after its strobe
      rd_pending <= mem_rd_en;
      if (rd_pending) acc <= acc + prod_ext;

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= len_clamped;
            bias_q    <= bias;
            shift_q   <= out_shift;
            relu_q    <= relu_en;
            acc       <= '0;
            rd_cnt    <= '0;
            feat_addr <= feat_base;
            wgt_addr  <= wgt_base;
          end
        end
        S_FETCH: begin
          rd_cnt    <= rd_cnt_inc;
          feat_addr <= feat_addr + ADDR_ONE;
          wgt_addr  <= wgt_addr + ADDR_ONE;
        end
        S_FINISH: begin
          result_out   <= res_sat;
          sat_flag     <= res_clip;
          result_valid <= 1'b1;
        end
        S_HOLD: begin
          if (result_valid && result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_npu_dot_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_dot_engine
// Description : Self-checking bench for npu_dot_engine. Behavioural RAMs feed
//               the engine, and a reference model pushes the expected result
//               of every job onto a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_dot_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [ADDR_W:0]          vec_len;
  logic [ADDR_W-1:0]        feat_base;
  logic [ADDR_W-1:0]        wgt_base;
  logic signed [DATA_W-1:0] bias;
  logic [3:0]               out_shift;
  logic                     relu_en;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        feat_addr;
  logic [ADDR_W-1:0]        wgt_addr;
  logic signed [DATA_W-1:0] feat_rdata;
  logic signed [DATA_W-1:0] wgt_rdata;
  logic signed [OUT_W-1:0]  result_out;
  logic                     result_valid;
  logic                     result_ready;
  logic                     busy;
  logic                     sat_flag;

  typedef struct {
    logic signed [OUT_W-1:0] res;
    logic                    sat;
    int                      lat;
  } exp_t;

  exp_t                     sb[$];
  logic [2*ADDR_W-1:0]      addr_log[$];
  logic signed [DATA_W-1:0] feat_mem[DEPTH];
  logic signed [DATA_W-1:0] wgt_mem[DEPTH];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  npu_dot_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .feat_base(feat_base), .wgt_base(wgt_base), .bias(bias),
    .out_shift(out_shift), .relu_en(relu_en), .mem_rd_en(mem_rd_en),
    .feat_addr(feat_addr), .wgt_addr(wgt_addr), .feat_rdata(feat_rdata),
    .wgt_rdata(wgt_rdata), .result_out(result_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .sat_flag(sat_flag)
  );

  // Synchronous RAMs; junk on the data bus whenever no read is issued
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) begin
      feat_rdata <= feat_mem[feat_addr];
      wgt_rdata  <= wgt_mem[wgt_addr];
      addr_log.push_back({feat_addr, wgt_addr});
    end else begin
      feat_rdata <= DATA_W'($urandom);
      wgt_rdata  <= DATA_W'($urandom);
    end
  end

  function automatic exp_t model(input int fb, input int wb, input int vl,
                                 input int b, input int sh, input bit relu);
    exp_t   e;
    longint acc = 0;
    longint v;
    longint hi = (longint'(1) << (OUT_W-1)) - 1;
    longint lo = -hi - 1;
    int     len = (vl > DEPTH) ? DEPTH : vl;
    for (int k = 0; k < len; k++)
      acc += longint'(feat_mem[(fb+k)%DEPTH]) * longint'(wgt_mem[(wb+k)%DEPTH]);
    acc += b;
    v = acc >>> sh;
    if (relu && v < 0) v = 0;
    e.sat = 1'b0;
    if (v > hi) begin v = hi; e.sat = 1'b1; end
    else if (v < lo) begin v = lo; e.sat = 1'b1; end
    e.res = OUT_W'(v);
    e.lat = len + 2;
    return e;
  endfunction

  // Drive a start pulse; afterwards scramble the job inputs to prove they were latched
  task automatic launch(input int fb, input int wb, input int vl, input int b,
                        input int sh, input bit relu);
    feat_base = ADDR_W'(fb);
    wgt_base  = ADDR_W'(wb);
    vec_len   = (ADDR_W+1)'(vl);
    bias      = DATA_W'(b);
    out_shift = 4'(sh);
    relu_en   = relu;
    start     = 1'b1;
    sb.push_back(model(fb, wb, vl, b, sh, relu));
    @(posedge clk); #1;
    start     = 1'b0;
    feat_base = ADDR_W'($urandom);
    wgt_base  = ADDR_W'($urandom);
    vec_len   = (ADDR_W+1)'($urandom);
    bias      = DATA_W'($urandom);
    out_shift = 4'($urandom);
    relu_en   = 1'($urandom);
  endtask

  // Count edges after the start-accepting edge until result_valid, bounded
  task automatic wait_valid(output int edges, output bit to);
    edges = 0;
    to    = 1'b0;
    while (result_valid !== 1'b1) begin
      if (edges >= 100) begin to = 1'b1; break; end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic load_basic();
    feat_mem[0] = 10; feat_mem[1] = 5;  feat_mem[2] = 2;
    wgt_mem[0]  = 2;  wgt_mem[1]  = -3; wgt_mem[2]  = 4;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; result_ready = 1'b1;
    vec_len = '0; feat_base = '0; wgt_base = '0; bias = '0;
    out_shift = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); end
    tests++; if (feat_addr !== '0) begin fails++; $display("FAIL reset_feat_addr: got %0d want 0", feat_addr); end
    tests++; if (wgt_addr !== '0) begin fails++; $display("FAIL reset_wgt_addr: got %0d want 0", wgt_addr); end
    tests++; if (result_out !== '0) begin fails++; $display("FAIL reset_result_out: got %0d want 0", result_out); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e; int n; bit to;
    load_basic();
    launch(0, 0, 3, 5, 0, 0);
    wait_valid(n, to);
    e = sb.pop_front();
    tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL basic_result: got %0d want %0d", result_out, e.res); end
    tests++; if (sat_flag !== e.sat) begin fails++; $display("FAIL basic_sat: got %b want %b", sat_flag, e.sat); end
    tests++; if (to || n != e.lat) begin fails++; $display("FAIL basic_latency: got %0d want %0d", n, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e; int n; bit to;
    feat_mem[0] = 100; feat_mem[1] = 100; wgt_mem[0] = 100; wgt_mem[1] = 100;
    for (int i = 0; i < 2; i++) begin
      launch(0, 0, 2, 0, (i == 0) ? 0 : 8, 0);
      wait_valid(n, to);
      e = sb.pop_front();
      tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL sat_result[%0d]: got %0d want %0d", i, result_out, e.res); end
      tests++; if (sat_flag !== e.sat) begin fails++; $display("FAIL sat_flag[%0d]: got %b want %b", i, sat_flag, e.sat); end
      tests++; if (to || n != e.lat) begin fails++; $display("FAIL sat_latency[%0d]: got %0d want %0d", i, n, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_relu_wrap();
    exp_t e; int n; bit to;
    feat_mem[15] = 10; feat_mem[0] = -1; wgt_mem[15] = -2; wgt_mem[0] = 3;
    for (int i = 0; i < 2; i++) begin
      addr_log.delete();
      launch(15, 15, 2, 0, 0, i[0]);
      wait_valid(n, to);
      e = sb.pop_front();
      tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL relu_result[%0d]: got %0d want %0d", i, result_out, e.res); end
      tests++; if (sat_flag !== e.sat) begin fails++; $display("FAIL relu_sat[%0d]: got %b want %b", i, sat_flag, e.sat); end
      tests++;
      if (addr_log.size() != 2 || addr_log[0] !== 8'hFF || addr_log[1] !== 8'h00) begin
        fails++; $display("FAIL wrap_addr[%0d]: got %0d reads want 2 reads at 15 then 0", i, addr_log.size());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_len();
    exp_t e; int n; bit to;
    addr_log.delete();
    launch(0, 0, 0, -7, 0, 0);
    wait_valid(n, to);
    e = sb.pop_front();
    tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL zero_result: got %0d want %0d", result_out, e.res); end
    tests++; if (sat_flag !== e.sat) begin fails++; $display("FAIL zero_sat: got %b want %b", sat_flag, e.sat); end
    tests++; if (to || n != e.lat) begin fails++; $display("FAIL zero_latency: got %0d want %0d", n, e.lat); end
    tests++; if (addr_log.size() != 0) begin fails++; $display("FAIL zero_reads: got %0d reads want 0", addr_log.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp_and_random();
    exp_t e; int n; bit to;
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < DEPTH; a++) begin
        feat_mem[a] = DATA_W'($urandom);
        wgt_mem[a]  = DATA_W'($urandom);
      end
      if (i == 0) launch(3, 9, 20, -50, 2, 0);
      else launch($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 17),
                  $signed(DATA_W'($urandom)), $urandom_range(0, 15), 1'($urandom));
      wait_valid(n, to);
      e = sb.pop_front();
      tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL rand_result[%0d]: got %0d want %0d", i, result_out, e.res); end
      tests++; if (sat_flag !== e.sat) begin fails++; $display("FAIL rand_sat[%0d]: got %b want %b", i, sat_flag, e.sat); end
      tests++; if (to || n != e.lat) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, n, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n; bit to;
    load_basic();
    result_ready = 1'b0;
    launch(0, 0, 3, 5, 0, 0);
    wait_valid(n, to);
    e = sb.pop_front();
    tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL bp_result: got %0d want %0d", result_out, e.res); end
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      @(posedge clk); #1;
      tests++;
      if (result_out !== e.res || sat_flag !== e.sat || result_valid !== 1'b1 || busy !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d]: got res=%0d sat=%b valid=%b busy=%b want res=%0d sat=%b valid=1 busy=1",
                          i, result_out, sat_flag, result_valid, busy, e.res, e.sat);
      end
    end
    // Start coincides with the transfer edge and must be ignored
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL bp_xfer_valid: got %b want 0", result_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_xfer_busy: got %b want 0", busy); end
    tests++; if (result_out !== e.res) begin fails++; $display("FAIL bp_xfer_hold: got %0d want %0d", result_out, e.res); end
    launch(0, 0, 3, 5, 0, 0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_restart_busy: got %b want 1", busy); end
    wait_valid(n, to);
    e = sb.pop_front();
    tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL bp_next_result: got %0d want %0d", result_out, e.res); end
    tests++; if (to || n != e.lat) begin fails++; $display("FAIL bp_next_latency: got %0d want %0d", n, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e; int n; bit to; bit seen;
    for (int a = 0; a < DEPTH; a++) begin
      feat_mem[a] = DATA_W'($urandom);
      wgt_mem[a]  = DATA_W'($urandom);
    end
    launch(0, 0, 16, 0, 0, 0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (mem_rd_en !== 1'b0 || feat_addr !== '0 || wgt_addr !== '0 || result_out !== '0 ||
        result_valid !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got rd=%b fa=%0d wa=%0d res=%0d valid=%b busy=%b sat=%b want all 0",
                        mem_rd_en, feat_addr, wgt_addr, result_out, result_valid, busy, sat_flag);
    end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_no_result: got activity=1 want 0"); end
    load_basic();
    launch(0, 0, 3, 5, 0, 0);
    wait_valid(n, to);
    e = sb.pop_front();
    tests++; if (to || result_out !== e.res) begin fails++; $display("FAIL midrst_next_result: got %0d want %0d", result_out, e.res); end
    tests++; if (to || n != e.lat) begin fails++; $display("FAIL midrst_next_latency: got %0d want %0d", n, e.lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu_wrap();
    test_zero_len();
    test_clamp_and_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
